// File: rtl/omega_net_pkg.sv
// Shared constants for the omega network: switch select codes, loader states, and a clog2 helper.
package omega_net_pkg;

  localparam logic [1:0] SEL_PASS   = 2'b00;
  localparam logic [1:0] SEL_CROSS  = 2'b01;
  localparam logic [1:0] SEL_BCAST0 = 2'b10;
  localparam logic [1:0] SEL_BCAST1 = 2'b11;

  localparam logic [1:0] LD_EMPTY   = 2'd0;
  localparam logic [1:0] LD_LOADING = 2'd1;
  localparam logic [1:0] LD_FULL    = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/omega_sw2x2_v.sv
// Combinational 2x2 switch on {valid,data}; broadcast duplicates the valid bit along with the data.
module omega_sw2x2_v
  import omega_net_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1
);

  always_comb begin
    out0 = in0;
    out1 = in1;
    case (sel)
      SEL_PASS:   begin out0 = in0; out1 = in1; end
      SEL_CROSS:  begin out0 = in1; out1 = in0; end
      SEL_BCAST0: begin out0 = in0; out1 = in0; end
      SEL_BCAST1: begin out0 = in1; out1 = in1; end
      default:    begin out0 = in0; out1 = in1; end
    endcase
  end

endmodule

// File: rtl/reg_pipe.sv
// Enable-gated register chain of NUM_STAGES stages with asynchronous active-low reset.
module reg_pipe #(
  parameter int WIDTH      = 1,
  parameter int NUM_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_reg [NUM_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_STAGES; k++) pipe_reg[k] <= '0;
    end else if (en) begin
      pipe_reg[0] <= d;
      for (int k = 1; k < NUM_STAGES; k++) pipe_reg[k] <= pipe_reg[k-1];
    end
  end

  assign q = pipe_reg[NUM_STAGES-1];

endmodule

// File: rtl/omega_net_pipe_cfg.sv
// Pipelined N-lane omega network with a double-buffered switch configuration
// whose shadow-to-active swap rides a commit token alongside the data.
module omega_net_pipe_cfg
  import omega_net_pkg::*;
#(
  parameter int N          = 8,
  parameter int WIDTH      = 16,
  parameter int STAGES     = 3,
  parameter int PIPE_EXTRA = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic               conf_valid,
  output logic               conf_ready,
  input  logic [N-1:0]       conf_data,
  input  logic               conf_commit,
  output logic               conf_err,
  output logic               conf_busy
);

  localparam int LW      = WIDTH + 1;
  localparam int HALF    = N / 2;
  localparam int DEPTH   = PIPE_EXTRA + 1;
  localparam int TOK_LEN = (STAGES + 1) * DEPTH;
  localparam int CW      = clog2(STAGES + 1);

  // Boundary b register input/output; lane i packed as {valid,data} at [i*LW +: LW].
  wire [N*LW-1:0] bnd_d [STAGES+1];
  wire [N*LW-1:0] bnd_q [STAGES+1];

  logic [N-1:0]   active_reg [STAGES];
  logic [N-1:0]   shadow_reg [STAGES];
  logic [N-1:0]   snap_reg   [STAGES];
  logic [N-1:0]   sel_eff    [STAGES];
  logic [1:0]     ld_state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [TOK_LEN-1:0] tok_reg;
  logic           pend_reg;
  logic           err_reg;

  logic word_acc;
  logic launch;
  logic tok_in;

  assign launch     = conf_commit && (ld_state_reg == LD_FULL);
  assign tok_in     = launch || pend_reg;
  assign conf_busy  = (|tok_reg) || pend_reg;
  assign conf_ready = (ld_state_reg != LD_FULL) && !conf_busy;
  assign word_acc   = conf_valid && conf_ready;
  assign conf_err   = err_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign bnd_d[0][gi*LW +: LW]      = {in_valid[gi], in_data[gi*WIDTH +: WIDTH]};
      assign out_data[gi*WIDTH +: WIDTH] = bnd_q[STAGES][gi*LW +: WIDTH];
      assign out_valid[gi]               = bnd_q[STAGES][gi*LW + WIDTH];
    end

    for (gi = 0; gi <= STAGES; gi++) begin : g_bnd
      reg_pipe #(.WIDTH(N*LW), .NUM_STAGES(DEPTH)) u_bnd (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (bnd_d[gi]),
        .q   (bnd_q[gi])
      );
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // The vector sitting next to the token must already see the new settings.
      assign sel_eff[gi] = tok_reg[(gi+1)*DEPTH-1] ? snap_reg[gi] : active_reg[gi];
      for (gj = 0; gj < HALF; gj++) begin : g_sw
        omega_sw2x2_v #(.W(LW)) u_sw (
          .sel  (sel_eff[gi][2*gj +: 2]),
          .in0  (bnd_q[gi][gj*LW +: LW]),
          .in1  (bnd_q[gi][(gj+HALF)*LW +: LW]),
          .out0 (bnd_d[gi+1][(2*gj)*LW +: LW]),
          .out1 (bnd_d[gi+1][(2*gj+1)*LW +: LW])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_reg <= LD_EMPTY;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        shadow_reg[k] <= '0;
        snap_reg[k]   <= '0;
      end
    end else begin
      err_reg <= conf_commit && (ld_state_reg != LD_FULL);
      if (launch) begin
        ld_state_reg <= LD_EMPTY;
        cnt_reg      <= '0;
        for (int k = 0; k < STAGES; k++) snap_reg[k] <= shadow_reg[k];
      end else if (word_acc) begin
        for (int k = 0; k < STAGES; k++)
          if (cnt_reg == CW'(k)) shadow_reg[k] <= conf_data;
        cnt_reg      <= cnt_reg + CW'(1);
        ld_state_reg <= (cnt_reg == CW'(STAGES-1)) ? LD_FULL : LD_LOADING;
      end
    end
  end

  // A commit seen while frozen waits in pend_reg and joins the next advancing vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_reg  <= '0;
      pend_reg <= 1'b0;
    end else if (en) begin
      tok_reg  <= {tok_reg[TOK_LEN-2:0], tok_in};
      pend_reg <= 1'b0;
    end else begin
      pend_reg <= tok_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) active_reg[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++)
        if (tok_reg[(k+1)*DEPTH-1]) active_reg[k] <= snap_reg[k];
    end
  end

endmodule
